mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter.sv | 168 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares the single MMU port between instruction fetch and data access.
// Data has fixed priority; misaligned requests are rejected without touching the MMU.
`ifndef MMU_WIDTH_BYTE
`define MMU_WIDTH_BYTE 2'd0
`endif
`ifndef MMU_WIDTH_HALF
`define MMU_WIDTH_HALF 2'd1
`endif
`ifndef MMU_WIDTH_WORD
`define MMU_WIDTH_WORD 2'd2
`endif

module mem_port_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  output logic        if_error,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [1:0]  d_width,
  input  logic        d_signed,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic        d_error,
  output logic        busy,
  input  logic        mmu_mem_ready,
  input  logic [31:0] mmu_data_out,
  output logic        mmu_read_enable,
  output logic        mmu_write_enable,
  output logic        mmu_mem_signed_read,
  output logic [1:0]  mmu_mem_data_width,
  output logic [31:0] mmu_address,
  output logic [31:0] mmu_data_in
);

  typedef enum logic [1:0] {IDLE, IFETCH, DATA} state_t;

  state_t      state, state_nx;
  logic        drop, drop_nx;
  logic        re_nx, we_nx, sg_nx;
  logic [1:0]  wd_nx;
  logic [31:0] addr_nx, din_nx;
  logic        if_ack_nx, if_err_nx, d_ack_nx, d_err_nx;
  logic [31:0] if_rd_nx, d_rd_nx;
  logic        d_mis, if_mis;

  assign d_mis  = ((d_width == `MMU_WIDTH_HALF) && d_addr[0]) ||
                  ((d_width == `MMU_WIDTH_WORD) && (d_addr[1:0] != 2'b00));
  assign if_mis = (if_addr[1:0] != 2'b00);
  assign busy   = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state               <= IDLE;
      drop                <= 1'b0;
      mmu_read_enable     <= 1'b0;
      mmu_write_enable    <= 1'b0;
      mmu_mem_signed_read <= 1'b0;
      mmu_mem_data_width  <= `MMU_WIDTH_WORD;
      mmu_address         <= '0;
      mmu_data_in         <= '0;
      if_ack              <= 1'b0;
      if_error            <= 1'b0;
      if_rdata            <= '0;
      d_ack               <= 1'b0;
      d_error             <= 1'b0;
      d_rdata             <= '0;
    end else begin
      state               <= state_nx;
      drop                <= drop_nx;
      mmu_read_enable     <= re_nx;
      mmu_write_enable    <= we_nx;
      mmu_mem_signed_read <= sg_nx;
      mmu_mem_data_width  <= wd_nx;
      mmu_address         <= addr_nx;
      mmu_data_in         <= din_nx;
      if_ack              <= if_ack_nx;
      if_error            <= if_err_nx;
      if_rdata            <= if_rd_nx;
      d_ack               <= d_ack_nx;
      d_error             <= d_err_nx;
      d_rdata             <= d_rd_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    drop_nx   = drop;
    re_nx     = mmu_read_enable;
    we_nx     = mmu_write_enable;
    sg_nx     = mmu_mem_signed_read;
    wd_nx     = mmu_mem_data_width;
    addr_nx   = mmu_address;
    din_nx    = mmu_data_in;
    if_ack_nx = 1'b0;
    if_err_nx = 1'b0;
    if_rd_nx  = if_rdata;
    d_ack_nx  = 1'b0;
    d_err_nx  = 1'b0;
    d_rd_nx   = d_rdata;

    unique case (state)
      IDLE: begin
        if (d_req) begin
          if (d_mis) begin
            d_ack_nx = 1'b1;
            d_err_nx = 1'b1;
            d_rd_nx  = '0;
          end else begin
            state_nx = DATA;
            addr_nx  = d_addr;
            wd_nx    = d_width;
            re_nx    = ~d_we;
            we_nx    = d_we;
            sg_nx    = ~d_we & d_signed;
            din_nx   = d_we ? d_wdata : '0;
          end
        end else if (if_req && !if_flush) begin
          if (if_mis) begin
            if_ack_nx = 1'b1;
            if_err_nx = 1'b1;
            if_rd_nx  = '0;
          end else begin
            state_nx = IFETCH;
            drop_nx  = 1'b0;
            addr_nx  = if_addr;
            wd_nx    = `MMU_WIDTH_WORD;
            re_nx    = 1'b1;
            we_nx    = 1'b0;
            sg_nx    = 1'b0;
            din_nx   = '0;
          end
        end
      end
      IFETCH, DATA: begin
        // A flush in the completing cycle still suppresses the fetch ack.
        if (state == IFETCH && if_flush) drop_nx = 1'b1;
        if (mmu_mem_ready) begin
          state_nx = IDLE;
          drop_nx  = 1'b0;
          re_nx    = 1'b0;
          we_nx    = 1'b0;
          sg_nx    = 1'b0;
          wd_nx    = `MMU_WIDTH_WORD;
          addr_nx  = '0;
          din_nx   = '0;
          if (state == IFETCH) begin
            if (!(drop || if_flush)) begin
              if_ack_nx = 1'b1;
              if_rd_nx  = mmu_data_out;
            end
          end else begin
            d_ack_nx = 1'b1;
            d_rd_nx  = mmu_write_enable ? '0 : mmu_data_out;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-level reference model.
`ifndef MMU_WIDTH_BYTE
`define MMU_WIDTH_BYTE 2'd0
`endif
`ifndef MMU_WIDTH_HALF
`define MMU_WIDTH_HALF 2'd1
`endif
`ifndef MMU_WIDTH_WORD
`define MMU_WIDTH_WORD 2'd2
`endif

module tb_mem_port_arbiter;

  logic        clk, reset;
  logic        if_req, if_flush, if_ack, if_error;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_signed, d_ack, d_error;
  logic [1:0]  d_width;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        busy, mmu_mem_ready;
  logic [31:0] mmu_data_out;
  logic        mmu_read_enable, mmu_write_enable, mmu_mem_signed_read;
  logic [1:0]  mmu_mem_data_width;
  logic [31:0] mmu_address, mmu_data_in;

  mem_port_arbiter dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_ack(if_ack), .if_rdata(if_rdata), .if_error(if_error),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_width(d_width),
    .d_signed(d_signed), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_error(d_error),
    .busy(busy),
    .mmu_mem_ready(mmu_mem_ready), .mmu_data_out(mmu_data_out),
    .mmu_read_enable(mmu_read_enable), .mmu_write_enable(mmu_write_enable),
    .mmu_mem_signed_read(mmu_mem_signed_read), .mmu_mem_data_width(mmu_mem_data_width),
    .mmu_address(mmu_address), .mmu_data_in(mmu_data_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: one outstanding transaction record plus pending acks.
  logic        t_act, t_fetch, t_we, t_signed, t_drop;
  logic [1:0]  t_width;
  logic [31:0] t_addr, t_wdata;
  logic        e_if_ack, e_if_err, e_d_ack, e_d_err;
  logic [31:0] e_if_rdata, e_d_rdata;

  function automatic int unsigned access_bytes(input logic [1:0] w);
    case (w)
      `MMU_WIDTH_BYTE: return 1;
      `MMU_WIDTH_HALF: return 2;
      default:         return 4;
    endcase
  endfunction

  task automatic model_step();
    e_if_ack = 1'b0; e_if_err = 1'b0; e_d_ack = 1'b0; e_d_err = 1'b0;
    if (reset) begin
      t_act = 1'b0; t_drop = 1'b0;
      e_if_rdata = '0; e_d_rdata = '0;
    end else if (!t_act) begin
      if (d_req) begin
        if (d_addr % access_bytes(d_width) != 0) begin
          e_d_ack = 1'b1; e_d_err = 1'b1; e_d_rdata = '0;
        end else begin
          t_act = 1'b1; t_fetch = 1'b0; t_drop = 1'b0;
          t_addr = d_addr; t_we = d_we; t_width = d_width;
          t_signed = d_we ? 1'b0 : d_signed;
          t_wdata  = d_we ? d_wdata : 32'd0;
        end
      end else if (if_req && !if_flush) begin
        if (if_addr % 4 != 0) begin
          e_if_ack = 1'b1; e_if_err = 1'b1; e_if_rdata = '0;
        end else begin
          t_act = 1'b1; t_fetch = 1'b1; t_drop = 1'b0;
          t_addr = if_addr; t_we = 1'b0; t_width = `MMU_WIDTH_WORD;
          t_signed = 1'b0; t_wdata = '0;
        end
      end
    end else begin
      if (t_fetch && if_flush) t_drop = 1'b1;
      if (mmu_mem_ready) begin
        t_act = 1'b0;
        if (t_fetch) begin
          if (!t_drop) begin e_if_ack = 1'b1; e_if_rdata = mmu_data_out; end
        end else begin
          e_d_ack = 1'b1;
          e_d_rdata = t_we ? 32'd0 : mmu_data_out;
        end
      end
    end
  endtask

  task automatic check_outputs();
    logic [9:0]  ctl_obs, ctl_exp;
    logic [1:0]  exp_w;
    exp_w   = t_act ? t_width : `MMU_WIDTH_WORD;
    ctl_obs = {busy, if_ack, if_error, d_ack, d_error, mmu_read_enable, mmu_write_enable,
               mmu_mem_signed_read, mmu_mem_data_width};
    ctl_exp = {t_act, e_if_ack, e_if_err, e_d_ack, e_d_err, t_act && !t_we, t_act && t_we,
               t_act && t_signed, exp_w};
    check_eq("ctl", {22'd0, ctl_obs}, {22'd0, ctl_exp});
    check_eq("mmu_address", mmu_address, t_act ? t_addr : 32'd0);
    check_eq("mmu_data_in", mmu_data_in, (t_act && t_we) ? t_wdata : 32'd0);
    check_eq("if_rdata", if_rdata, e_if_rdata);
    check_eq("d_rdata", d_rdata, e_d_rdata);
  endtask

  // MMU responder state
  int unsigned mmu_wait;
  logic        mmu_counting;

  task automatic drive_inputs(input int cyc);
    logic [31:0] r;
    if_flush = 1'b0;
    reset    = (cyc < 2) || ($urandom_range(0, 199) == 0);
    if (reset) begin
      if_req = 1'b0; d_req = 1'b0;
    end else begin
      // Data requester: holds until ack, sometimes drops after grant.
      if (d_req && d_ack) d_req = 1'b0;
      else if (d_req && t_act && !t_fetch && $urandom_range(0, 7) == 0) d_req = 1'b0;
      else if (!d_req && $urandom_range(0, 3) == 0) begin
        d_req    = 1'b1;
        d_we     = $urandom_range(0, 1) == 1;
        d_width  = 2'($urandom_range(0, 2));
        d_signed = $urandom_range(0, 1) == 1;
        d_wdata  = $urandom;
        r        = $urandom & 32'h0000_FFFC;
        d_addr   = ($urandom_range(0, 5) == 0) ? r + 32'($urandom_range(1, 3)) : r;
      end
      // Fetch requester: flush pulses, withdrawal before grant, new requests.
      if (if_req && (if_ack || if_error)) if_req = 1'b0;
      else if ($urandom_range(0, 11) == 0) begin
        if_flush = 1'b1; if_req = 1'b0;
      end else if (if_req && !(t_act && t_fetch) && $urandom_range(0, 9) == 0) if_req = 1'b0;
      else if (!if_req && $urandom_range(0, 2) == 0) begin
        if_req  = 1'b1;
        r       = $urandom & 32'h0000_FFFC;
        if_addr = ($urandom_range(0, 7) == 0) ? r + 32'($urandom_range(1, 3)) : r;
      end
    end
    // MMU: random 0..4 wait states once an enable is seen; stray ready when idle.
    mmu_data_out = $urandom;
    if (!(mmu_read_enable || mmu_write_enable)) begin
      mmu_counting  = 1'b0;
      mmu_mem_ready = ($urandom_range(0, 7) == 0);
    end else begin
      if (!mmu_counting) begin
        mmu_counting = 1'b1;
        mmu_wait     = $urandom_range(0, 4);
      end
      if (mmu_wait == 0) begin
        mmu_mem_ready = 1'b1;
        mmu_counting  = 1'b0;
      end else begin
        mmu_mem_ready = 1'b0;
        mmu_wait--;
      end
    end
  endtask

  initial begin
    reset = 1'b1; if_req = 1'b0; if_flush = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_width = `MMU_WIDTH_WORD;
    d_signed = 1'b0; d_wdata = '0; mmu_mem_ready = 1'b0; mmu_data_out = '0;
    t_act = 1'b0; t_fetch = 1'b0; t_we = 1'b0; t_signed = 1'b0; t_drop = 1'b0;
    t_width = `MMU_WIDTH_WORD; t_addr = '0; t_wdata = '0;
    e_if_ack = 1'b0; e_if_err = 1'b0; e_d_ack = 1'b0; e_d_err = 1'b0;
    e_if_rdata = '0; e_d_rdata = '0;
    mmu_wait = 0; mmu_counting = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clk);
      model_step();
      #1;
      check_outputs();
      drive_inputs(cyc);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
